// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache: combinational hits, 4-word line
// refill from instruction memory over a level request / ready-pulse handshake.
module icache_dm #(
    parameter int LINES = 8,
    parameter int IDX_W = $clog2(LINES),
    parameter int TAG_W = 30 - 2 - IDX_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          proc_read,
    input  logic          proc_write,
    input  logic [29:0]   proc_addr,
    input  logic [31:0]   proc_wdata,
    output logic [31:0]   proc_rdata,
    output logic          proc_stall,
    output logic          mem_read,
    output logic          mem_write,
    output logic [27:0]   mem_addr,
    output logic [127:0]  mem_wdata,
    input  logic [127:0]  mem_rdata,
    input  logic          mem_ready
);

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [27:0]        miss_q, miss_d;
    logic [LINES-1:0]   valid_q;
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [127:0]       data_q [LINES];

    logic [IDX_W-1:0]   curIdx;
    logic [TAG_W-1:0]   curTag;
    logic [1:0]         curOff;
    logic [IDX_W-1:0]   fillIdx;
    logic [TAG_W-1:0]   fillTag;
    logic [127:0]       curLine;
    logic               hit;
    logic               fillEn;
    logic               unusedInputs;

    assign curIdx  = proc_addr[IDX_W+1:2];
    assign curTag  = proc_addr[29:IDX_W+2];
    assign curOff  = proc_addr[1:0];
    assign fillIdx = miss_q[IDX_W-1:0];
    assign fillTag = miss_q[27:IDX_W];

    assign hit     = valid_q[curIdx] && (tag_q[curIdx] == curTag);
    assign fillEn  = (state_q == FETCH) && mem_ready;
    assign curLine = data_q[curIdx];

    // The core never writes instruction memory, so the write side is dropped.
    assign unusedInputs = ^{proc_write, proc_wdata};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            miss_q  <= '0;
        end else begin
            state_q <= state_d;
            miss_q  <= miss_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (fillEn) begin
            valid_q[fillIdx] <= 1'b1;
        end
    end

    // Tags and data need no reset: they are only trusted behind a valid bit.
    always_ff @(posedge clk) begin
        if (fillEn) begin
            tag_q[fillIdx]  <= fillTag;
            data_q[fillIdx] <= mem_rdata;
        end
    end

    always_comb begin
        state_d = state_q;
        miss_d  = miss_q;
        case (state_q)
            IDLE: begin
                if (proc_read && !hit) begin
                    state_d = FETCH;
                    miss_d  = proc_addr[29:2];
                end
            end
            FETCH: begin
                if (mem_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        proc_stall = 1'b0;
        mem_read   = 1'b0;
        case (state_q)
            IDLE: begin
                proc_stall = proc_read && !hit;
            end
            FETCH: begin
                proc_stall = 1'b1;
                mem_read   = 1'b1;
            end
            default: begin
                proc_stall = 1'b1;
            end
        endcase
    end

    assign proc_rdata = curLine[{curOff, 5'b00000} +: 32];
    assign mem_addr   = miss_q;
    assign mem_write  = 1'b0;
    assign mem_wdata  = '0;

endmodule

// File: tb/tb_icache_dm.sv
// Directed self-checking bench for icache_dm: cold fill, hits, eviction,
// ignored writes, reset during a fetch and an address change mid-miss.
module tb_icache_dm;

    logic          clk;
    logic          rst_n;
    logic          proc_read;
    logic          proc_write;
    logic [29:0]   proc_addr;
    logic [31:0]   proc_wdata;
    logic [31:0]   proc_rdata;
    logic          proc_stall;
    logic          mem_read;
    logic          mem_write;
    logic [27:0]   mem_addr;
    logic [127:0]  mem_wdata;
    logic [127:0]  mem_rdata;
    logic          mem_ready;

    int checks;
    int errors;

    localparam logic [127:0] LINE0 = {32'h00000013, 32'h00500093, 32'h00a00113, 32'h002081b3};
    localparam logic [127:0] LINE1 = {32'h11110003, 32'h11110002, 32'h11110001, 32'h11110000};
    localparam logic [127:0] LINE2 = {32'h22220003, 32'h22220002, 32'h22220001, 32'h22220000};
    localparam logic [127:0] LINE3 = {32'h33330003, 32'h33330002, 32'h33330001, 32'h33330000};
    localparam logic [127:0] LINE4 = {32'h44440003, 32'h44440002, 32'h44440001, 32'h44440000};
    localparam logic [127:0] JUNK  = {4{32'hBAD0BAD0}};

    icache_dm dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .proc_read  (proc_read),
        .proc_write (proc_write),
        .proc_addr  (proc_addr),
        .proc_wdata (proc_wdata),
        .proc_rdata (proc_rdata),
        .proc_stall (proc_stall),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after a rising edge, outputs are sampled 1 unit later.
    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Memory model: answers once mem_read has been seen lat times; stops when stall drops.
    task automatic serveMemory(input logic [127:0] line, input int lat,
                               output int stalls, output logic [27:0] seenAddr,
                               output bit timedOut);
        int rd;
        stalls   = 0;
        rd       = 0;
        timedOut = 1'b1;
        seenAddr = '1;
        for (int c = 0; c < 50; c++) begin
            #1;
            if (!proc_stall) begin
                timedOut = 1'b0;
                return;
            end
            stalls++;
            if (mem_read) begin
                rd++;
                seenAddr = mem_addr;
                if (rd == lat) begin
                    mem_ready = 1'b1;
                    mem_rdata = line;
                end
            end
            stepCycle();
            mem_ready = 1'b0;
            mem_rdata = '0;
        end
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        proc_read  = 1'b1;
        proc_write = 1'b0;
        proc_addr  = 30'h0;
        proc_wdata = '0;
        mem_rdata  = '0;
        mem_ready  = 1'b0;
        #3;
        checks++; if (proc_stall !== 1'b1) begin errors++; $display("[TB] FAIL reset_stall: got %b want 1", proc_stall); end
        checks++; if (mem_read !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_read: got %b want 0", mem_read); end
        checks++; if (mem_write !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_write: got %b want 0", mem_write); end
        checks++; if (mem_addr !== 28'h0) begin errors++; $display("[TB] FAIL reset_mem_addr: got %h want 0", mem_addr); end
        checks++; if (mem_wdata !== 128'h0) begin errors++; $display("[TB] FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
        proc_read = 1'b0;
        #1;
        checks++; if (proc_stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_noread_stall: got %b want 0", proc_stall); end
        stepCycle();
        rst_n = 1'b1;
    endtask

    task automatic test_cold_fetch();
        int stalls; logic [27:0] a; bit to;
        stepCycle();
        proc_read = 1'b1;
        proc_addr = 30'h0;
        serveMemory(LINE0, 3, stalls, a, to);
        checks++; if (to) begin errors++; $display("[TB] FAIL cold_timeout: stall never dropped"); end
        checks++; if (stalls !== 4) begin errors++; $display("[TB] FAIL cold_stall_cycles: got %0d want 4", stalls); end
        checks++; if (a !== 28'h0) begin errors++; $display("[TB] FAIL cold_mem_addr: got %h want 0", a); end
        checks++; if (proc_rdata !== 32'h002081b3) begin errors++; $display("[TB] FAIL cold_rdata: got %h want 002081b3", proc_rdata); end
    endtask

    task automatic test_seq_hits();
        logic [31:0] exp [3];
        exp[0] = 32'h00a00113;
        exp[1] = 32'h00500093;
        exp[2] = 32'h00000013;
        for (int i = 0; i < 3; i++) begin
            stepCycle();
            proc_read = 1'b1;
            proc_addr = 30'(i + 1);
            #1;
            checks++; if (proc_stall !== 1'b0) begin errors++; $display("[TB] FAIL hit_stall[%0d]: got %b want 0", i + 1, proc_stall); end
            checks++; if (proc_rdata !== exp[i]) begin errors++; $display("[TB] FAIL hit_rdata[%0d]: got %h want %h", i + 1, proc_rdata, exp[i]); end
            checks++; if (mem_read !== 1'b0) begin errors++; $display("[TB] FAIL hit_mem_read[%0d]: got %b want 0", i + 1, mem_read); end
        end
    endtask

    task automatic test_write_ignored();
        stepCycle();
        proc_read  = 1'b0;
        proc_write = 1'b1;
        proc_addr  = 30'h1;
        proc_wdata = 32'hDEADBEEF;
        #1;
        checks++; if (proc_stall !== 1'b0) begin errors++; $display("[TB] FAIL write_stall: got %b want 0", proc_stall); end
        checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin errors++; $display("[TB] FAIL write_mem_traffic: got rd=%b wr=%b want 0 0", mem_read, mem_write); end
        stepCycle();
        proc_write = 1'b0;
        proc_wdata = '0;
        proc_read  = 1'b1;
        #1;
        checks++; if (mem_read !== 1'b0) begin errors++; $display("[TB] FAIL write_no_fetch: got %b want 0", mem_read); end
        checks++; if (proc_stall !== 1'b0) begin errors++; $display("[TB] FAIL write_reread_stall: got %b want 0", proc_stall); end
        checks++; if (proc_rdata !== 32'h00a00113) begin errors++; $display("[TB] FAIL write_reread_rdata: got %h want 00a00113", proc_rdata); end
    endtask

    task automatic test_conflict();
        int stalls; logic [27:0] a; bit to;
        stepCycle();
        proc_read = 1'b1;
        proc_addr = 30'h20;
        #1;
        checks++; if (proc_stall !== 1'b1) begin errors++; $display("[TB] FAIL conflict_miss: got %b want 1", proc_stall); end
        #1;
        stepCycle();
        serveMemory(LINE1, 2, stalls, a, to);
        checks++; if (to || stalls !== 2) begin errors++; $display("[TB] FAIL conflict_stall_cycles: got %0d (timeout %b) want 2 after detect", stalls, to); end
        checks++; if (a !== 28'h08) begin errors++; $display("[TB] FAIL conflict_mem_addr: got %h want 08", a); end
        checks++; if (proc_rdata !== 32'h11110000) begin errors++; $display("[TB] FAIL conflict_rdata: got %h want 11110000", proc_rdata); end
        stepCycle();
        proc_addr = 30'h0;
        #1;
        checks++; if (proc_stall !== 1'b1) begin errors++; $display("[TB] FAIL evicted_miss: got %b want 1", proc_stall); end
        #1;
        stepCycle();
        serveMemory(LINE0, 1, stalls, a, to);
        checks++; if (to || stalls !== 1 || a !== 28'h0) begin errors++; $display("[TB] FAIL evicted_refill: got stalls=%0d addr=%h want 1 0", stalls, a); end
        checks++; if (proc_rdata !== 32'h002081b3) begin errors++; $display("[TB] FAIL evicted_rdata: got %h want 002081b3", proc_rdata); end
    endtask

    task automatic test_reset_fetch();
        int stalls; logic [27:0] a; bit to;
        stepCycle();
        proc_read = 1'b1;
        proc_addr = 30'h8;
        stepCycle();
        #1;
        checks++; if (mem_read !== 1'b1 || mem_addr !== 28'h02) begin errors++; $display("[TB] FAIL rstf_fetching: got rd=%b addr=%h want 1 02", mem_read, mem_addr); end
        rst_n     = 1'b0;
        proc_read = 1'b0;
        #1;
        checks++; if (mem_read !== 1'b0) begin errors++; $display("[TB] FAIL rstf_mem_read_drop: got %b want 0", mem_read); end
        checks++; if (mem_addr !== 28'h0) begin errors++; $display("[TB] FAIL rstf_mem_addr: got %h want 0", mem_addr); end
        stepCycle();
        rst_n     = 1'b1;
        mem_ready = 1'b1;
        mem_rdata = JUNK;
        stepCycle();
        mem_ready = 1'b0;
        mem_rdata = '0;
        proc_read = 1'b1;
        #1;
        checks++; if (proc_stall !== 1'b1) begin errors++; $display("[TB] FAIL rstf_still_invalid: got %b want 1", proc_stall); end
        checks++; if (mem_read !== 1'b0) begin errors++; $display("[TB] FAIL rstf_idle_ready_ignored: got %b want 0", mem_read); end
        #1;
        stepCycle();
        serveMemory(LINE2, 1, stalls, a, to);
        checks++; if (to || a !== 28'h02) begin errors++; $display("[TB] FAIL rstf_refill: got addr=%h timeout=%b want 02 0", a, to); end
        checks++; if (proc_rdata !== 32'h22220000) begin errors++; $display("[TB] FAIL rstf_rdata: got %h want 22220000", proc_rdata); end
    endtask

    task automatic test_addr_change();
        int stalls; logic [27:0] a; bit to;
        stepCycle();
        proc_read = 1'b1;
        proc_addr = 30'h4;
        #1;
        checks++; if (proc_stall !== 1'b1) begin errors++; $display("[TB] FAIL achg_miss: got %b want 1", proc_stall); end
        stepCycle();
        proc_addr = 30'h10;
        #1;
        checks++; if (mem_read !== 1'b1 || mem_addr !== 28'h01) begin errors++; $display("[TB] FAIL achg_latched: got rd=%b addr=%h want 1 01", mem_read, mem_addr); end
        stepCycle();
        mem_ready = 1'b1;
        mem_rdata = LINE3;
        stepCycle();
        mem_ready = 1'b0;
        mem_rdata = '0;
        #1;
        checks++; if (proc_stall !== 1'b1 || mem_read !== 1'b0) begin errors++; $display("[TB] FAIL achg_new_miss: got stall=%b rd=%b want 1 0", proc_stall, mem_read); end
        stepCycle();
        serveMemory(LINE4, 1, stalls, a, to);
        checks++; if (to || a !== 28'h04) begin errors++; $display("[TB] FAIL achg_mem_addr: got %h timeout=%b want 04 0", a, to); end
        checks++; if (proc_rdata !== 32'h44440000) begin errors++; $display("[TB] FAIL achg_new_rdata: got %h want 44440000", proc_rdata); end
        stepCycle();
        proc_addr = 30'h4;
        #1;
        checks++; if (proc_stall !== 1'b0 || proc_rdata !== 32'h33330000) begin errors++; $display("[TB] FAIL achg_old_line: got stall=%b rdata=%h want 0 33330000", proc_stall, proc_rdata); end
    endtask

    task automatic test_back_to_back();
        int stalls; logic [27:0] a; bit to;
        stepCycle();
        proc_addr = 30'h0C;
        serveMemory(LINE1, 1, stalls, a, to);
        checks++; if (to || stalls !== 2 || a !== 28'h03) begin errors++; $display("[TB] FAIL b2b_first: got stalls=%0d addr=%h want 2 03", stalls, a); end
        stepCycle();
        proc_addr = 30'h1E;
        serveMemory(LINE2, 2, stalls, a, to);
        checks++; if (to || stalls !== 3 || a !== 28'h07) begin errors++; $display("[TB] FAIL b2b_second: got stalls=%0d addr=%h want 3 07", stalls, a); end
        checks++; if (proc_rdata !== 32'h22220002) begin errors++; $display("[TB] FAIL b2b_rdata: got %h want 22220002", proc_rdata); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_cold_fetch();
        test_seq_hits();
        test_write_ignored();
        test_conflict();
        test_reset_fetch();
        test_addr_change();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/icache_dm.md
# icache_dm

Direct-mapped, read-only instruction cache between the pipeline's IF-stage I-cache port and the slow instruction memory. Hits return a word combinationally in the request cycle with no stall. Misses raise `proc_stall`, fetch a 4-word line from memory through a level handshake, fill the line, then serve the word. Writes from the processor side are accepted and ignored, since instruction memory is never written by the core.

## Interface
- `LINES`, default 8: number of cache lines; power of two, at least 2.
- `IDX_W`, default log2(`LINES`) = 3: index width.
- `TAG_W`, default 30-2-`IDX_W` = 25: tag width.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `proc_read` input 1: fetch request (pipeline `ICACHE_ren`).
- `proc_write` input 1: write request (pipeline `ICACHE_wen`); ignored.
- `proc_addr` input 30: word address; [1:0] word offset, [`IDX_W`+1:2] index, [29:`IDX_W`+2] tag.
- `proc_wdata` input 32: ignored.
- `proc_rdata` output 32: fetched instruction; valid when `proc_read` is high and `proc_stall` is low.
- `proc_stall` output 1: pipeline must hold `proc_addr`/`proc_read` and freeze.
- `mem_read` output 1: line read request to memory.
- `mem_write` output 1: tied to 0.
- `mem_addr` output 28: line address, equal to `proc_addr[29:2]` latched at miss.
- `mem_wdata` output 128: tied to 0.
- `mem_rdata` input 128: line data; word k is at bits [32k+31:32k].
- `mem_ready` input 1: one-cycle pulse; `mem_rdata` is valid in that cycle.

## Operation
- Storage per line: valid bit, `TAG_W` tag, 128-bit data. Only valid bits need reset; data and tags are don't-care while invalid.
- `hit` = valid[idx] && tag[idx] == addr tag, evaluated combinationally on the current `proc_addr`.
- FSM states are IDLE and FETCH.
- **IDLE behaviour:**
  - `proc_stall` = `proc_read` && !`hit`.
  - `proc_rdata` = word `proc_addr[1:0]` of line idx. It is driven regardless of hit; a consumer only uses it on a non-stalled read.
  - On `proc_read` && !`hit`: latch `proc_addr[29:2]` into the miss register and go to FETCH.
- **FETCH behaviour:**
  - `mem_read` = 1 and `mem_addr` = miss register.
  - `proc_stall` = 1 unconditionally.
  - On `mem_ready`: write `mem_rdata` into the line selected by the latched index, set its tag and valid, and return to IDLE.
- The return to IDLE re-evaluates the current `proc_addr`. The address is normally unchanged, so the result is a hit with stall low.
- `proc_write` and `proc_wdata` have no effect on state or outputs. A cycle with `proc_write`=1 and `proc_read`=0 gives `proc_stall`=0.
- `proc_read`=0 in IDLE: no miss is started and `proc_stall`=0.
- Replacement: a miss overwrites the indexed line unconditionally. There is no write-back because lines are never dirty.

## Timing
- **Reset (async assert):**
  - All valid bits cleared, state IDLE, miss register 0.
  - `mem_read`=0, `mem_write`=0, `mem_addr`=0 (`mem_addr` = miss register, so it holds its value outside FETCH).
  - `proc_stall` = `proc_read` (everything misses).
- **Reset mid-FETCH:** the fetch is abandoned, the line is not filled, and `mem_read` drops asynchronously. A later `mem_ready` in IDLE is ignored.
- **Hit latency:** 0 cycles (combinational from `proc_addr`).
- **Miss latency:**
  - Cycle 0 is the IDLE miss detect, with stall high.
  - `mem_read` is high from cycle 1 until the `mem_ready` cycle N, inclusive.
  - The line is written at the end of cycle N; cycle N+1 is IDLE with a hit and stall low.
  - With a memory that answers after R cycles of `mem_read`, stall lasts R+1 cycles.
- **`mem_ready` outside FETCH:** ignored.
- **`proc_read` dropping during FETCH:** the fetch still completes and fills the line.
- **`proc_addr` changing during FETCH:** the fill uses the latched address. Stall after the return is decided on the new address, so a new miss can start immediately at N+1.
- **Back-to-back misses to different lines:** no idle gap other than the one IDLE cycle between fetches.
- **Aliasing:** addresses with the same index and a different tag evict each other. Each alternation costs a full miss.

## Test plan
- **Cold fetch after reset:** read addr 0x0000_0000; memory returns line {w3..w0} = {0x00000013, 0x00500093, 0x00a00113, 0x002081b3} after 3 cycles. Required: `mem_addr`=0, stall for 4 cycles, then `proc_rdata`=0x002081b3.
- **Sequential hits:** after the fill, read addresses 1, 2, 3 on consecutive cycles. Required: stall=0 each cycle, rdata = 0x00a00113, 0x00500093, 0x00000013, and `mem_read` stays 0.
- **Conflict eviction** (`LINES`=8): read 0x20 (same index 0, tag 1). Required: miss, `mem_addr`=0x08, fill. Re-reading 0x0 then misses again.
- **Write ignored:** `proc_write`=1, `proc_addr`=0x1, `proc_wdata`=0xDEADBEEF. Required: stall=0, no memory traffic, and a later read of 0x1 returns the original word.
- **Reset during FETCH:** assert `rst_n`=0 while `mem_read`=1. Required: `mem_read`=0 immediately, the line stays invalid, and the next read of that address misses again.
- **Address change mid-miss:** miss on 0x4, then switch `proc_addr` to 0x10 before `mem_ready`. Required: line 1 is filled for 0x4, the next cycle misses on 0x10, and `mem_addr`=0x04.
